// File: rtl/mic_stream_pkg.sv
// Shared sample definitions for the microphone pitch-detect stream path.
package mic_stream_pkg;
  localparam int SAMPLE_W      = 32;
  localparam int SAMPLE_W_FRAC = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/stream_skid_buf.sv
// Generic 2-entry valid/ready buffer; in_ready depends only on registered occupancy.
module stream_skid_buf
  import mic_stream_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        // push while full is blocked by in_ready, so this is always count 1
        2'b11: head <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_decimator.sv
// Keeps one sample in every DECIM input handshakes and re-emits it through a 2-entry buffer.
module stream_decimator
  import mic_stream_pkg::*;
#(
  parameter int W      = SAMPLE_W,
  parameter int W_FRAC = SAMPLE_W_FRAC,
  parameter int DECIM  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [W-1:0] x_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y_data
);

  localparam int            PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

  if (DECIM < 1 || DECIM > 256) begin : g_bad_decim
    $error("stream_decimator: DECIM must be in 1..256");
  end
  if (W_FRAC < 0 || W_FRAC > W) begin : g_bad_frac
    $error("stream_decimator: W_FRAC must be in 0..W");
  end

  logic [PW-1:0] phase;
  logic          keep_phase;
  logic          buf_ready;
  logic          x_fire;

  assign keep_phase = (phase == LAST);
  // discard-phase samples never touch the buffer, so only keep-phase can stall
  assign x_ready    = !keep_phase || buf_ready;
  assign x_fire     = x_valid & x_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (x_fire) begin
      if (keep_phase) phase <= '0;
      else            phase <= phase + 1'b1;
    end
  end

  stream_skid_buf #(
    .W (W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (x_valid & keep_phase),
    .in_ready  (buf_ready),
    .in_data   (x_data),
    .out_valid (y_valid),
    .out_ready (y_ready),
    .out_data  (y_data)
  );

endmodule

// File: tb/tb_stream_decimator.sv
// Scoreboard bench for stream_decimator at DECIM = 4, 1 and 3.
module tb_stream_decimator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        x_valid_a = 0, x_ready_a, y_valid_a, y_ready_a = 0;
  logic [31:0] x_data_a = 0, y_data_a;
  logic        x_valid_b = 0, x_ready_b, y_valid_b, y_ready_b = 0;
  logic [31:0] x_data_b = 0, y_data_b;
  logic        x_valid_c = 0, x_ready_c, y_valid_c, y_ready_c = 0;
  logic [31:0] x_data_c = 0, y_data_c;

  stream_decimator #(.DECIM(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid_a), .x_ready(x_ready_a), .x_data(x_data_a),
    .y_valid(y_valid_a), .y_ready(y_ready_a), .y_data(y_data_a));
  stream_decimator #(.DECIM(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid_b), .x_ready(x_ready_b), .x_data(x_data_b),
    .y_valid(y_valid_b), .y_ready(y_ready_b), .y_data(y_data_b));
  stream_decimator #(.DECIM(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid_c), .x_ready(x_ready_c), .x_data(x_data_c),
    .y_valid(y_valid_c), .y_ready(y_ready_c), .y_data(y_data_c));

  int checks = 0;
  int errors = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];
  int pa = 0;
  int pc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a handshake is decided by values held stable across the negedge.
  always @(negedge clk) begin
    if (rst_n && y_valid_a && y_ready_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_output: got %0h expected none", y_data_a);
      end else check("a_y_data", y_data_a, q_a.pop_front());
    end
  end
  always @(negedge clk) begin
    if (rst_n && y_valid_b && y_ready_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_output: got %0h expected none", y_data_b);
      end else check("b_y_data", y_data_b, q_b.pop_front());
    end
  end
  always @(negedge clk) begin
    if (rst_n && y_valid_c && y_ready_c) begin
      if (q_c.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected_output: got %0h expected none", y_data_c);
      end else check("c_y_data", y_data_c, q_c.pop_front());
    end
  end

  task automatic send_a(input logic [31:0] d, input int max_wait);
    bit ok = 0;
    x_valid_a = 1; x_data_a = d;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (x_ready_a) begin
        if (pa == 3) q_a.push_back(d);
        pa = (pa + 1) % 4;
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL a_send_timeout: got no handshake expected one for %0h", d);
    end
    x_valid_a = 0;
  endtask

  task automatic send_b(input logic [31:0] d, input int max_wait);
    bit ok = 0;
    x_valid_b = 1; x_data_b = d;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (x_ready_b) begin
        q_b.push_back(d);
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL b_send_timeout: got no handshake expected one for %0h", d);
    end
    x_valid_b = 0;
  endtask

  task automatic drain(input string name, input int which, input int max_wait);
    bit ok = 0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0) ||
          (which == 2 && q_c.size() == 0)) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain_timeout: got pending outputs expected none", name);
    end
  endtask

  initial begin
    bit          r2;
    logic        xr1;
    int          accepted;
    int          cyc;

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("a_reset_y_valid", {31'b0, y_valid_a}, 32'd0);
    check("a_reset_x_ready", {31'b0, x_ready_a}, 32'd1);
    check("a_reset_y_data", y_data_a, 32'd0);
    check("c_reset_x_ready", {31'b0, x_ready_c}, 32'd1);

    // 1..8 with downstream ready: one-cycle pulses carrying 4 and 8
    y_ready_a = 1;
    for (int i = 1; i <= 8; i++) begin
      send_a(i, 5);
      check("a_pulse_y_valid", {31'b0, y_valid_a}, (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    drain("a_pulse", 0, 10);

    // 1..11 with downstream stalled, then 12 stalls on the full buffer
    y_ready_a = 0;
    for (int i = 1; i <= 11; i++) send_a(i, 5);
    x_valid_a = 1; x_data_a = 12;
    repeat (3) begin
      @(negedge clk);
      check("a_full_x_ready", {31'b0, x_ready_a}, 32'd0);
      check("a_full_hold_data", y_data_a, 32'd4);
      check("a_full_hold_valid", {31'b0, y_valid_a}, 32'd1);
    end
    check("a_full_phase_hold", pa, 3);
    @(posedge clk); #1;
    y_ready_a = 1;
    send_a(12, 10);
    drain("a_backpressure", 0, 10);
    check("a_x_ready_restored", {31'b0, x_ready_a}, 32'd1);

    // push and pop on the same edge at count 1
    y_ready_a = 0;
    for (int i = 1; i <= 7; i++) send_a(i, 5);
    y_ready_a = 1;
    send_a(8, 5);
    check("a_pushpop_y_valid", {31'b0, y_valid_a}, 32'd1);
    check("a_pushpop_y_data", y_data_a, 32'd8);
    drain("a_pushpop", 0, 10);

    // async reset with count 2 and phase 2
    y_ready_a = 0;
    for (int i = 1; i <= 10; i++) send_a(i, 5);
    check("a_prereset_y_valid", {31'b0, y_valid_a}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("a_async_y_valid", {31'b0, y_valid_a}, 32'd0);
    check("a_async_x_ready", {31'b0, x_ready_a}, 32'd1);
    check("a_async_y_data", y_data_a, 32'd0);
    q_a.delete();
    pa = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    y_ready_a = 1;
    for (int i = 21; i <= 24; i++) send_a(i, 5);
    drain("a_after_reset", 0, 10);
    check("a_after_reset_idle", {31'b0, y_valid_a}, 32'd0);

    // DECIM=1, downstream ready toggling every cycle
    fork
      begin
        send_b(32'h0001_0000, 10);
        send_b(32'hFFFF_0000, 10);
      end
      repeat (8) begin
        @(posedge clk); #1;
        y_ready_b = ~y_ready_b;
      end
    join
    y_ready_b = 1;
    drain("b_toggle", 1, 10);
    check("b_idle", {31'b0, y_valid_b}, 32'd0);

    // DECIM=3 random soak; y_ready is flipped mid-cycle to probe x_ready independence
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      x_valid_c = ($urandom_range(0, 3) != 0);
      x_data_c  = $urandom;
      r2 = $urandom_range(0, 1);
      y_ready_c = ~r2;
      #2 xr1 = x_ready_c;
      y_ready_c = r2;
      #1 check("c_xready_indep", {31'b0, x_ready_c}, {31'b0, xr1});
      @(negedge clk);
      if (x_valid_c && x_ready_c) begin
        if (pc == 2) q_c.push_back(x_data_c);
        pc = (pc + 1) % 3;
        accepted++;
      end
      cyc++;
    end
    check("c_soak_accepted", accepted, 10000);
    @(posedge clk); #1;
    x_valid_c = 0;
    y_ready_c = 1;
    drain("c_soak", 2, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_decimator.md
# stream_decimator

Integer-factor sample-rate decimator on the microphone pitch-detect path. Sits directly downstream of the anti-alias low-pass FIR: consumes its valid/ready output stream, keeps one sample in every `DECIM`, and re-emits it on a valid/ready stream toward the pitch estimator. A 2-entry output buffer decouples backpressure, so `x_ready` never depends combinationally on `y_ready`.

## Interface
- `W`, 32, sample width in bits (two's complement fixed point).
- `W_FRAC`, 16, fractional bits; carried through unchanged, no arithmetic applied.
- `DECIM`, 4, decimation factor, legal range 1..256.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `x_valid`  in  1  input sample valid (from FIR `y_valid`).
- `x_ready`  out  1  input ready (to FIR `y_ready`).
- `x_data`  in  W  input sample.
- `y_valid`  out  1  output sample valid.
- `y_ready`  in  1  downstream ready.
- `y_data`  out  W  output sample.

## Operation
- Input handshake: `x_valid & x_ready` at a rising edge. Output handshake: `y_valid & y_ready` at a rising edge.
- Phase counter `phase`, width `$clog2(DECIM)` (min 1), resets to 0.
  - Advances on every input handshake.
  - Wraps `DECIM-1 -> 0`.
- Keep condition: input handshake with `phase == DECIM-1`. Every other input handshake is discarded.
- `DECIM == 1`: every sample is kept.
- Buffer: 2 entries (`head`, `tail`) with occupancy `count` in 0..2.
  - `y_valid = (count != 0)`.
  - `y_data = head`.
- `x_ready = (phase != DECIM-1) || (count != 2)`. This is a registered-state function only.
  - Discard-phase samples are always accepted.
  - A keep-phase sample stalls only when the buffer is full.
- Update rules, with `push` = keep handshake and `pop` = output handshake:
  - `push` only, count 0: `head <= x_data`, count 1.
  - `push` only, count 1: `tail <= x_data`, count 2.
  - `pop` only, count 2: `head <= tail`, count 1.
  - `pop` only, count 1: count 0.
  - `push & pop`, count 1: `head <= x_data`, count stays 1.
  - `push & pop`, count 2: cannot occur, because `x_ready` is low on the keep phase when full.
- `pop` with count 0: cannot occur, because `y_valid` is low.
- Data is not modified: no rounding, scaling or saturation.

## Timing
- Reset values: `y_valid = 0`, `x_ready = 1`, `y_data = 0`, `phase = 0`, `count = 0`, `head = tail = 0`.
- Reset asserted mid-stream: all buffered samples are dropped immediately (asynchronous). The first sample after release is phase 0.
- Latency: a kept sample accepted at edge k is presented with `y_valid = 1` after edge k. The earliest downstream handshake is at edge k+1.
- Throughput: with `y_ready` held high, one output per `DECIM` input handshakes, with no stalls.
- Ordering: outputs appear in input order; none lost or duplicated while `rst_n` is high.
- `y_valid` and `y_data` are held stable until popped (AXI-stream rule).
- A sample accepted while `x_valid` stays high and `x_ready` is low does not count as a handshake; `phase` holds.

## Structure
- Shared package `mic_stream_pkg`:
  - `SAMPLE_W = 32`.
  - `SAMPLE_W_FRAC = 16`.
  - `typedef logic signed [SAMPLE_W-1:0] sample_t`.
- The top level uses the package defaults for `W` and `W_FRAC`.
- Sub-module `stream_skid_buf` is the generic 2-entry valid/ready buffer.
  - Ports: `clk`, `rst_n`, `in_valid`, `in_ready`, `in_data`, `out_valid`, `out_ready`, `out_data`.
  - `in_ready = (count != 2)`.
  - The decimator wraps it with the phase counter and keep gating.

## Test plan
- Reset, then 8 consecutive samples 1..8 with `y_ready = 1` and DECIM=4 -> outputs 4, 8. Each `y_valid` pulse lasts 1 cycle, starting the cycle after samples 4 and 8 are accepted.
- `y_ready = 0`, 12 samples 1..12 -> samples 4 and 8 are buffered and `x_ready` drops on sample 12. Raising `y_ready` then yields 4, 8, 12 in order, and `x_ready` returns high.
- DECIM=1, samples 0x00010000, 0xFFFF0000 with `y_ready` toggling every cycle -> both emitted bit-exact, in order, with no duplicates.
- Simultaneous push and pop at count 1: output 4 is popped on the same edge that sample 8 is kept -> count stays 1 and `y_data = 8` next cycle.
- Assert `rst_n = 0` asynchronously with count 2 and phase 2 -> `y_valid` goes 0 before the next edge. After release, 4 samples 21..24 -> single output 24.
- Random `x_valid`/`y_ready` soak, 10k samples, DECIM=3 -> scoreboard matches every 3rd accepted sample and `x_ready` never depends on same-cycle `y_ready`.
